// File: rtl/fp_div_arbiter.sv
// Round-robin arbiter sharing one stb/ack floating-point divider between NUM_REQ requesters.
// One operation is in flight at a time: grant, send a, send b, collect z, return z to the owner.
module fp_div_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [32*NUM_REQ-1:0]   req_a,
    input  logic [32*NUM_REQ-1:0]   req_b,
    output logic [NUM_REQ-1:0]      req_ack,
    output logic [NUM_REQ-1:0]      rsp_valid,
    output logic [31:0]             rsp_z,
    input  logic [NUM_REQ-1:0]      rsp_ack,
    output logic [31:0]             div_a,
    output logic                    div_a_stb,
    input  logic                    div_a_ack,
    output logic [31:0]             div_b,
    output logic                    div_b_stb,
    input  logic                    div_b_ack,
    input  logic [31:0]             div_z,
    input  logic                    div_z_stb,
    output logic                    div_z_ack,
    output logic                    busy,
    output logic [ID_W-1:0]         grant_id
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_Z,
        RESP
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [ID_W-1:0]     last_grant;
    logic [31:0]         a_reg;
    logic [31:0]         b_reg;
    logic [31:0]         z_reg;
    logic                pick_vld;
    logic [ID_W-1:0]     pick_id;
    logic [ID_W:0]       cand;

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    // Round-robin search starting one past the last grant, wrapping at NUM_REQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = last_grant;
        cand     = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = {1'b0, last_grant} + (ID_W+1)'(i);
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end
            if (!pick_vld && req_valid[cand[ID_W-1:0]]) begin
                pick_vld = 1'b1;
                pick_id  = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (pick_vld)          state_nx = SEND_A;
            SEND_A:  if (div_a_ack)         state_nx = SEND_B;
            SEND_B:  if (div_b_ack)         state_nx = WAIT_Z;
            WAIT_Z:  if (div_z_stb)         state_nx = RESP;
            RESP:    if (rsp_ack[grant_id]) state_nx = IDLE;
            default:                        state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ-1);
            grant_id   <= '0;
            req_ack    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            z_reg      <= '0;
        end else begin
            state   <= state_nx;
            req_ack <= '0;
            if (state == IDLE && pick_vld) begin
                a_reg      <= req_a[32*pick_id +: 32];
                b_reg      <= req_b[32*pick_id +: 32];
                grant_id   <= pick_id;
                last_grant <= pick_id;
                req_ack    <= ONE_HOT0 << pick_id;
            end
            // z is only taken while div_z_ack is high, so stray strobes are ignored.
            if (state == WAIT_Z && div_z_stb) begin
                z_reg <= div_z;
            end
        end
    end

    // All handshake outputs decode from registered state only.
    assign div_a     = a_reg;
    assign div_b     = b_reg;
    assign div_a_stb = (state == SEND_A);
    assign div_b_stb = (state == SEND_B);
    assign div_z_ack = (state == WAIT_Z);
    assign rsp_z     = z_reg;
    assign rsp_valid = (state == RESP) ? (ONE_HOT0 << grant_id) : '0;
    assign busy      = (state != IDLE);

endmodule

// File: doc/fp_div_arbiter.md
# fp_div_arbiter

Shares one single-precision floating-point divider (32-bit a/b/z stb/ack handshake) between NUM_REQ requesters using round-robin arbitration. For each granted request it captures the requester's operand pair and feeds a, then b, to the divider. It then collects z and returns z to that requester tagged by a one-hot valid. It sits between the collision-detection compute units and the divider instance, and is the only master of the divider's input and output handshakes.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- ID_W, 2: width of the grant index; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- req_valid  in  NUM_REQ  per-requester request; held high with stable operands until req_ack.
- req_a  in  32*NUM_REQ  dividend; requester i uses bits [32*i+31:32*i].
- req_b  in  32*NUM_REQ  divisor; same packing as req_a.
- req_ack  out  NUM_REQ  one-cycle, one-hot pulse; operands of that requester captured.
- rsp_valid  out  NUM_REQ  one-hot; result for requester i is valid on rsp_z.
- rsp_z  out  32  quotient, IEEE-754 single precision.
- rsp_ack  in  NUM_REQ  response consumed when rsp_valid[i] && rsp_ack[i].
- div_a / div_a_stb / div_a_ack  out 32 / out 1 / in 1  divider operand a handshake.
- div_b / div_b_stb / div_b_ack  out 32 / out 1 / in 1  divider operand b handshake.
- div_z / div_z_stb / div_z_ack  in 32 / in 1 / out 1  divider result handshake.
- busy  out  1  high in every state except IDLE.
- grant_id  out  ID_W  index of the current or last granted requester.

## Operation
- States: IDLE, SEND_A, SEND_B, WAIT_Z, RESP.
- Handshake rule, both sides: a transfer occurs on a cycle where stb and ack are both high. There is no combinational path from any input to any stb or ack output.
- IDLE: if any req_valid is high, choose g by round-robin.
  - Search starts at (last_grant+1) mod NUM_REQ and increases with wrap.
  - Registered on the same edge: a_reg=req_a[g], b_reg=req_b[g], grant_id=g, last_grant=g.
  - req_ack[g]=1 for the next cycle only; next state is SEND_A.
- SEND_A: div_a_stb=1, div_a=a_reg. On div_a_stb && div_a_ack, go to SEND_B; div_a_stb is 0 on the following cycle.
- SEND_B: div_b_stb=1, div_b=b_reg. On transfer, go to WAIT_Z.
- WAIT_Z: div_z_ack=1. On div_z_stb && div_z_ack, z_reg=div_z and go to RESP; div_z_ack is 0 on the following cycle.
- RESP: rsp_valid[grant_id]=1 and rsp_z=z_reg, held stable until rsp_ack[grant_id], then go to IDLE.
- div_a and div_b hold their last value when the matching stb is low. rsp_z holds z_reg.
- The arbiter does not inspect or alter values. NaN, inf and zero results pass through bit-exact.

## Timing
- Reset values: req_ack=0, rsp_valid=0, rsp_z=0, div_a=0, div_b=0, div_a_stb=0, div_b_stb=0, div_z_ack=0, busy=0, grant_id=0, last_grant=NUM_REQ-1, state=IDLE. Requester 0 wins the first arbitration.
- Reset mid-operation: the in-flight request is dropped and no response is issued. The divider must share the same reset so that the two stay in step. The arbiter has no recovery for a divider left mid-operation.
- Arbitration happens once per IDLE cycle. Minimum gap from a rsp_ack transfer to the next req_ack pulse is 2 cycles: the IDLE cycle, then the pulse.
- Overhead added to divider latency, with ack/stb immediately ready: grant 1, SEND_A 1, SEND_B 1, WAIT_Z capture 1, RESP ≥1 cycle.
- Only one operation is outstanding; no pipelining across requesters.
- A req_valid from the requester currently in service is not re-arbitrated until IDLE. A requester may re-request in the cycle after its rsp_ack and still gets fair rotation.
- rsp_ack on a non-granted bit, or outside RESP, is ignored.
- A spurious div_z_stb outside WAIT_Z is ignored, because div_z_ack is low.
- req_valid dropped before req_ack is a protocol violation. Behaviour is only defined if it is dropped while the arbiter is not in IDLE.

## Test plan
- Single request: requester 0 sends a=0x40C00000 (6.0), b=0x40000000 (2.0). Required: rsp_valid=4'b0001 and rsp_z=0x40400000 (3.0); req_ack pulses exactly once.
- Special values: requester 2 sends 0x3F800000/0x00000000. Required: rsp_z=0x7F800000. Then 0x00000000/0x00000000. Required: rsp_z=0xFFC00000, with rsp_valid=4'b0100 both times.
- Fairness: all four requesters hold req_valid continuously for 8 operations. Required grant order 0,1,2,3,0,1,2,3; each response goes only to its owner.
- Backpressure: hold div_a_ack low for 5 cycles, div_z_ack handling via a slow div_z_stb, and rsp_ack low for 7 cycles. Required: stb outputs and rsp_z stay stable, with no lost or duplicated transfers.
- Reset mid-WAIT_Z: assert rst for 1 cycle. Required: all outputs at reset values the next cycle; a new request from requester 1 completes correctly after reset.
- Wrap: after a grant to requester 3, only requesters 0 and 2 requesting. Required: 0 is granted before 2.
